// File: rtl/cluster_tcdm_arb_pkg.sv
// Shared types and defaults for the per-bank TCDM arbiter.
// Arbitration mode encoding and a debug snapshot exported through the bus interface.
package cluster_tcdm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED    = 2'd0,
    ARB_RR       = 2'd1,
    ARB_WEIGHTED = 2'd2,
    ARB_RSVD     = 2'd3
  } arb_mode_e;

  localparam int unsigned DEF_STALL_W  = 8;
  localparam int unsigned DEF_WEIGHT_W = 4;

  // Fixed-width view of internal state; fields are zero-extended from the
  // parameterised registers (N_REQ <= 32, WEIGHT_W <= 8).
  typedef struct packed {
    logic [4:0] rr_ptr;
    logic [7:0] wcnt;
    logic       starv_hit;
    logic       resp_valid;
  } arb_dbg_t;

endpackage

// File: rtl/cluster_tcdm_bank_arb_if.sv
// Initiator-side and bank-side signal bundle for the TCDM bank arbiter.
// Handshake: a port holds req with stable add/wen/data/be until gnt is seen high in the
// same cycle; for every gnt, r_valid for that port pulses exactly one cycle later.
interface cluster_tcdm_bank_arb_if #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = DW / 8
);
  import cluster_tcdm_arb_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] add;
  logic [N_REQ-1:0]    wen;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ*BW-1:0] be;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    r_valid;
  logic [DW-1:0]       r_data;

  logic                mem_req;
  logic [AW-1:0]       mem_add;
  logic                mem_wen;
  logic [DW-1:0]       mem_data;
  logic [BW-1:0]       mem_be;
  logic [DW-1:0]       mem_rdata;

  arb_dbg_t            dbg;

  modport slave (
    input  req, add, wen, data, be, mem_rdata,
    output gnt, r_valid, r_data, mem_req, mem_add, mem_wen, mem_data, mem_be, dbg
  );

  modport master (
    output req, add, wen, data, be, mem_rdata,
    input  gnt, r_valid, r_data, mem_req, mem_add, mem_wen, mem_data, mem_be, dbg
  );

endinterface

// File: rtl/cluster_tcdm_arb_sel.sv
// Masked ring priority encoder: first set bit of (req & mask) at or after start.
// start must be below N; the search wraps once around the vector.
module cluster_tcdm_arb_sel #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    int unsigned j;
    logic        found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j] && mask[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cluster_tcdm_bank_arb.sv
// Per-bank TCDM arbiter: fixed / round-robin / weighted policy with a starvation guard,
// combinational same-cycle grant and one-cycle response routing back to the winner.
module cluster_tcdm_bank_arb
  import cluster_tcdm_arb_pkg::*;
#(
  parameter int unsigned N_REQ                = 8,
  parameter int unsigned N_HI                 = 2,
  parameter int unsigned AW                   = 12,
  parameter int unsigned DW                   = 32,
  parameter int unsigned BW                   = DW / 8,
  parameter int unsigned STALL_W              = DEF_STALL_W,
  parameter int unsigned WEIGHT_W             = DEF_WEIGHT_W,
  parameter bit          FILTER_WRITE_R_VALID = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [1:0]          mode_i,
  input  logic [WEIGHT_W-1:0] weight_i,
  input  logic [STALL_W-1:0]  max_stall_i,
  cluster_tcdm_bank_arb_if.slave bus
);

  localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Grouping only matters when both groups are non-empty.
  localparam bit          GRP_EN = (N_HI != 0) && (N_HI < N_REQ);

  arb_mode_e mode;
  assign mode = arb_mode_e'(mode_i);

  logic [IW-1:0]                  rr_ptr;
  logic [WEIGHT_W-1:0]            wcnt;
  logic [N_REQ-1:0][STALL_W-1:0]  stall_cnt;
  logic                           resp_valid;
  logic [IW-1:0]                  resp_id;

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] all_mask;
  logic [N_REQ-1:0] starv_req;

  always_comb begin
    all_mask  = '1;
    hi_mask   = '0;
    starv_req = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      hi_mask[i]   = (i < int'(N_HI));
      starv_req[i] = bus.req[i] && (max_stall_i != '0) && (stall_cnt[i] >= max_stall_i);
    end
  end

  logic [N_REQ-1:0] starv_oh, fixed_oh, rr_oh, hi_oh, lo_oh;
  logic [IW-1:0]    starv_idx, fixed_idx, rr_idx, hi_idx, lo_idx;

  cluster_tcdm_arb_sel #(.N(N_REQ), .IW(IW)) u_sel_starv (
    .req(starv_req), .start('0), .mask(all_mask), .onehot(starv_oh), .idx(starv_idx)
  );
  cluster_tcdm_arb_sel #(.N(N_REQ), .IW(IW)) u_sel_fixed (
    .req(bus.req), .start('0), .mask(all_mask), .onehot(fixed_oh), .idx(fixed_idx)
  );
  cluster_tcdm_arb_sel #(.N(N_REQ), .IW(IW)) u_sel_rr (
    .req(bus.req), .start(rr_ptr), .mask(all_mask), .onehot(rr_oh), .idx(rr_idx)
  );
  cluster_tcdm_arb_sel #(.N(N_REQ), .IW(IW)) u_sel_hi (
    .req(bus.req), .start(rr_ptr), .mask(hi_mask), .onehot(hi_oh), .idx(hi_idx)
  );
  cluster_tcdm_arb_sel #(.N(N_REQ), .IW(IW)) u_sel_lo (
    .req(bus.req), .start(rr_ptr), .mask(~hi_mask), .onehot(lo_oh), .idx(lo_idx)
  );

  logic                starv_hit;
  logic                hi_any, lo_any;
  logic [WEIGHT_W-1:0] eff_weight;
  logic [N_REQ-1:0]    win_oh;
  logic [IW-1:0]       win_idx;
  logic                win_valid;
  logic                hi_win;

  assign starv_hit  = |starv_req;
  assign hi_any     = |(bus.req & hi_mask);
  assign lo_any     = |(bus.req & ~hi_mask);
  assign eff_weight = (weight_i == '0) ? WEIGHT_W'(1) : weight_i;
  assign win_valid  = |bus.req;
  assign hi_win     = |(win_oh & hi_mask);

  always_comb begin
    win_oh  = rr_oh;
    win_idx = rr_idx;
    if (starv_hit) begin
      win_oh  = starv_oh;
      win_idx = starv_idx;
    end else begin
      case (mode)
        ARB_FIXED: begin
          win_oh  = fixed_oh;
          win_idx = fixed_idx;
        end
        ARB_WEIGHTED: begin
          // With only one group requesting, plain RR already stays inside that group.
          if (GRP_EN && hi_any && lo_any) begin
            if (wcnt < eff_weight) begin
              win_oh  = hi_oh;
              win_idx = hi_idx;
            end else begin
              win_oh  = lo_oh;
              win_idx = lo_idx;
            end
          end
        end
        default: begin
          win_oh  = rr_oh;
          win_idx = rr_idx;
        end
      endcase
    end
  end

  logic [AW-1:0] mem_add;
  logic          mem_wen;
  logic [DW-1:0] mem_data;
  logic [BW-1:0] mem_be;

  always_comb begin
    mem_add  = '0;
    mem_wen  = 1'b0;
    mem_data = '0;
    mem_be   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_oh[i]) begin
        mem_add  = mem_add  | bus.add[i*AW +: AW];
        mem_wen  = mem_wen  | bus.wen[i];
        mem_data = mem_data | bus.data[i*DW +: DW];
        mem_be   = mem_be   | bus.be[i*BW +: BW];
      end
    end
  end

  logic [IW-1:0] next_ptr;
  assign next_ptr = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      wcnt       <= '0;
      stall_cnt  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
    end else if (clear_i) begin
      rr_ptr     <= '0;
      wcnt       <= '0;
      stall_cnt  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
    end else begin
      if (win_valid) rr_ptr <= next_ptr;
      // Weight counter only advances while the low group is actually held off.
      if (GRP_EN && (mode == ARB_WEIGHTED)) begin
        if (!lo_any || (win_valid && !hi_win)) wcnt <= '0;
        else if (win_valid && (wcnt != '1))    wcnt <= wcnt + WEIGHT_W'(1);
      end
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (bus.req[i] && !win_oh[i]) begin
          if (stall_cnt[i] != '1) stall_cnt[i] <= stall_cnt[i] + STALL_W'(1);
        end else begin
          stall_cnt[i] <= '0;
        end
      end
      resp_valid <= win_valid && (!FILTER_WRITE_R_VALID || mem_wen);
      if (win_valid) resp_id <= win_idx;
    end
  end

  logic [N_REQ-1:0] r_valid;
  always_comb begin
    r_valid = '0;
    if (resp_valid) r_valid[resp_id] = 1'b1;
  end

  assign bus.gnt      = win_oh;
  assign bus.r_valid  = r_valid;
  assign bus.r_data   = resp_valid ? bus.mem_rdata : '0;
  assign bus.mem_req  = win_valid;
  assign bus.mem_add  = mem_add;
  assign bus.mem_wen  = mem_wen;
  assign bus.mem_data = mem_data;
  assign bus.mem_be   = mem_be;

  assign bus.dbg.rr_ptr     = 5'(rr_ptr);
  assign bus.dbg.wcnt       = 8'(wcnt);
  assign bus.dbg.starv_hit  = starv_hit;
  assign bus.dbg.resp_valid = resp_valid;

endmodule
